// File: rtl/store_pkg.sv
// Shared definitions for the store deserialiser: store widths, FSM states
// and the base byte-lane masks that get shifted into position.
package store_pkg;

    // Store width encodings as carried on func[1:0].
    typedef enum logic [1:0] {
        ST_B   = 2'b00,
        ST_H   = 2'b01,
        ST_W   = 2'b10,
        ST_ILL = 2'b11
    } store_func_e;

    // Store sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        WRITE = 2'b10,
        ERROR = 2'b11
    } store_state_e;

    // Base lane masks before shifting by the byte offset.
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/store_deserialiser_if.sv
// Write-request bus between the store deserialiser and the masked BlockRAM.
//
// Handshake: the master raises mem_wr_valid and holds mem_addr, mem_data and
// mem_mask stable until a cycle in which mem_wr_ready is also high; the write
// is transferred in that cycle and valid drops afterwards. valid never depends
// on ready, and ready may be asserted at any time.
interface store_deserialiser_if #(
    parameter int D_WIDTH    = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0]    mem_data;
    logic [3:0]            mem_mask;
    logic                  mem_wr_valid;
    logic                  mem_wr_ready;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_mask,
        output mem_wr_valid,
        input  mem_wr_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_mask,
        input  mem_wr_valid,
        output mem_wr_ready
    );
endinterface

// File: rtl/store_lane_align.sv
// Lane alignment for SB/SH/SW: replicates the low byte/halfword across the
// word so no barrel shifter is needed, and lets the mask pick the lanes.
// Also flags stores whose offset does not suit their width.
module store_lane_align
    import store_pkg::*;
(
    input  store_func_e func,
    input  logic [1:0]  byte_off,
    input  logic [31:0] sreg,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_mask,
    output logic        misaligned_cond
);

    // Data replication, lane mask and misalignment check per store width.
    always_comb begin
        mem_data        = sreg;
        mem_mask        = 4'b0000;
        misaligned_cond = 1'b0;
        case (func)
            ST_B: begin
                mem_data = {4{sreg[7:0]}};
                mem_mask = MASK_B << byte_off;
            end
            ST_H: begin
                mem_data        = {2{sreg[15:0]}};
                mem_mask        = MASK_H << byte_off;
                misaligned_cond = byte_off[0];
            end
            ST_W: begin
                mem_data        = sreg;
                mem_mask        = MASK_W;
                misaligned_cond = |byte_off;
            end
            default: begin
                misaligned_cond = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_deserialiser.sv
// Collects a 32-bit LSB-first store stream, lane-aligns it and issues one
// masked write request. Misaligned or illegal stores consume the stream,
// pulse misaligned/done and never write.
module store_deserialiser
    import store_pkg::*;
#(
    parameter int D_WIDTH    = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            func,
    input  logic [1:0]            byte_off,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  busy,
    output logic                  misaligned,
    output logic                  done,
    output store_state_e          dbg_state,
    store_deserialiser_if.master  mem
);

    store_state_e          state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [D_WIDTH-1:0]    sreg_q, sreg_d;
    store_func_e           func_q, func_d;
    logic [1:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    // Registered write payload: holds its value outside WRITE.
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [D_WIDTH-1:0]    mem_data_q;
    logic [3:0]            mem_mask_q;

    logic [D_WIDTH-1:0]    sreg_shift;
    logic [31:0]           lane_data;
    logic [3:0]            lane_mask;
    logic                  lane_misaligned;
    logic                  capture;
    logic                  wr_valid;

    // func[2] carries no meaning for stores.
    logic                  unused_func_msb;
    assign unused_func_msb = func[2];

    // Shift register value after accepting the current bit; aligning this
    // lets the payload be captured on the same edge as the final bit.
    assign sreg_shift = {bit_in, sreg_q[D_WIDTH-1:1]};

    store_lane_align u_align (
        .func            (func_q),
        .byte_off        (off_q),
        .sreg            (sreg_shift),
        .mem_data        (lane_data),
        .mem_mask        (lane_mask),
        .misaligned_cond (lane_misaligned)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        func_d     = func_q;
        off_d      = off_q;
        addr_d     = addr_q;
        capture    = 1'b0;
        wr_valid   = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    func_d  = store_func_e'(func[1:0]);
                    off_d   = byte_off;
                    addr_d  = addr_in;
                    cnt_d   = 5'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    sreg_d = sreg_shift;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        if (lane_misaligned) begin
                            state_d = ERROR;
                        end else begin
                            capture = 1'b1;
                            state_d = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                wr_valid = 1'b1;
                if (mem.mem_wr_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            ERROR: begin
                misaligned = 1'b1;
                done       = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, shift register and latched store parameters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            sreg_q  <= '0;
            func_q  <= ST_B;
            off_q   <= 2'b00;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            func_q  <= func_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
        end
    end

    // Write payload captured on entry to WRITE and held afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_mask_q <= 4'b0000;
        end else if (capture) begin
            mem_addr_q <= addr_q;
            mem_data_q <= lane_data;
            mem_mask_q <= lane_mask;
        end
    end

    assign mem.mem_addr     = mem_addr_q;
    assign mem.mem_data     = mem_data_q;
    assign mem.mem_mask     = (state_q == WRITE) ? mem_mask_q : 4'b0000;
    assign mem.mem_wr_valid = wr_valid;
    assign busy             = (state_q != IDLE);
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_store_deserialiser.sv
// Directed bench for store_deserialiser: SW/SB/SH writes with stalls,
// misaligned stores, reset mid-stream and start-pulse corner cases.
module tb_store_deserialiser;
    import store_pkg::*;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   func;
    logic [1:0]   byte_off;
    logic [9:0]   addr_in;
    logic         bit_in;
    logic         bit_valid;
    logic         busy;
    logic         misaligned;
    logic         done;
    store_state_e dbg_state;

    store_deserialiser_if #(.D_WIDTH(32), .ADDR_WIDTH(10)) bus ();

    store_deserialiser #(.D_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .func       (func),
        .byte_off   (byte_off),
        .addr_in    (addr_in),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .misaligned (misaligned),
        .done       (done),
        .dbg_state  (dbg_state),
        .mem        (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected write items: {addr, mask, data}.
    logic [45:0] exp_q[$];
    logic        seen_wr;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every handshake must match the oldest expected write.
    always @(negedge clk) begin
        #2;
        if (bus.mem_wr_valid === 1'b1 && bus.mem_wr_ready === 1'b1) begin
            if (exp_q.size() == 0)
                check("wr_unexpected", 64'd1, 64'd0);
            else
                check("wr_item", {18'd0, bus.mem_addr, bus.mem_mask, bus.mem_data},
                      {18'd0, exp_q.pop_front()});
        end
    end

    always @(posedge clk) begin
        if (bus.mem_wr_valid === 1'b1) seen_wr <= 1'b1;
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the start pulse.
    task automatic pulse_start(input logic [2:0] f, input logic [1:0] o, input logic [9:0] a);
        start    = 1'b1;
        func     = f;
        byte_off = o;
        addr_in  = a;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Streams 32 bits LSB first; gap inserts an idle cycle after each bit.
    // poke >= 0 raises start with a conflicting SW/off=3 request at that bit.
    task automatic shift_bits(input logic [31:0] word, input bit gap, input int poke);
        for (int i = 0; i < 32; i++) begin
            bit_valid = 1'b1;
            bit_in    = word[i];
            if (i == poke) begin
                start    = 1'b1;
                func     = 3'b010;
                byte_off = 2'b11;
            end else begin
                start    = 1'b0;
            end
            @(negedge clk);
            if (gap) begin
                bit_valid = 1'b0;
                start     = 1'b0;
                @(negedge clk);
            end
        end
        bit_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Called at the negedge after the last bit; state should be WRITE.
    task automatic finish_write(input logic [9:0] a, input logic [3:0] m, input logic [31:0] d,
                                input int stall, input bit start_with_done);
        exp_q.push_back({a, m, d});
        for (int k = 0; k < stall; k++) begin
            bus.mem_wr_ready = 1'b0;
            #1;
            check("stall_valid", {63'd0, bus.mem_wr_valid}, 64'd1);
            check("stall_done",  {63'd0, done}, 64'd0);
            check("stall_data",  {32'd0, bus.mem_data}, {32'd0, d});
            check("stall_mask",  {60'd0, bus.mem_mask}, {60'd0, m});
            @(negedge clk);
        end
        bus.mem_wr_ready = 1'b1;
        if (start_with_done) begin
            start    = 1'b1;
            func     = 3'b000;
            byte_off = 2'b00;
        end
        #1;
        check("wr_valid", {63'd0, bus.mem_wr_valid}, 64'd1);
        check("wr_data",  {32'd0, bus.mem_data}, {32'd0, d});
        check("wr_mask",  {60'd0, bus.mem_mask}, {60'd0, m});
        check("wr_addr",  {54'd0, bus.mem_addr}, {54'd0, a});
        check("wr_done",  {63'd0, done}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        bus.mem_wr_ready = 1'b0;
        #1;
        check("post_busy",  {63'd0, busy}, 64'd0);
        check("post_done",  {63'd0, done}, 64'd0);
        check("post_mask",  {60'd0, bus.mem_mask}, 64'd0);
        check("post_valid", {63'd0, bus.mem_wr_valid}, 64'd0);
        check("post_hold",  {32'd0, bus.mem_data}, {32'd0, d});
    endtask

    // Called at the negedge after the last bit; state should be ERROR.
    task automatic finish_error(input string tag);
        #1;
        check({tag, "_mis"},   {63'd0, misaligned}, 64'd1);
        check({tag, "_done"},  {63'd0, done}, 64'd1);
        check({tag, "_valid"}, {63'd0, bus.mem_wr_valid}, 64'd0);
        @(negedge clk);
        #1;
        check({tag, "_mis_end"},  {63'd0, misaligned}, 64'd0);
        check({tag, "_done_end"}, {63'd0, done}, 64'd0);
        check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst              = 1'b0;
        start            = 1'b0;
        func             = 3'b000;
        byte_off         = 2'b00;
        addr_in          = 10'h000;
        bit_in           = 1'b0;
        bit_valid        = 1'b0;
        bus.mem_wr_ready = 1'b0;
        seen_wr          = 1'b0;

        @(negedge clk);
        #1;
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
        check("rst_data",  {32'd0, bus.mem_data}, 64'd0);
        check("rst_addr",  {54'd0, bus.mem_addr}, 64'd0);
        check("rst_valid", {63'd0, bus.mem_wr_valid}, 64'd0);
        check("rst_done",  {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // SW word write; a start coincident with done is ignored.
        pulse_start(3'b010, 2'd0, 10'h05A);
        #1 check("sw_busy", {63'd0, busy}, 64'd1);
        shift_bits(32'hDEADBEEF, 1'b0, -1);
        finish_write(10'h05A, 4'hF, 32'hDEADBEEF, 0, 1'b1);

        // A start one cycle after done is accepted: SB at offset 1.
        pulse_start(3'b000, 2'd1, 10'h111);
        #1 check("start_after_done_busy", {63'd0, busy}, 64'd1);
        shift_bits(32'h000000C3, 1'b0, -1);
        finish_write(10'h111, 4'b0010, 32'hC3C3C3C3, 0, 1'b0);

        // SB at offset 2 with a conflicting start mid-stream.
        pulse_start(3'b100, 2'd2, 10'h2A0);
        shift_bits(32'h123456A5, 1'b0, 5);
        finish_write(10'h2A0, 4'b0100, 32'hA5A5A5A5, 0, 1'b0);

        // SH at offset 2, stream gapped, memory stalls 3 cycles.
        pulse_start(3'b001, 2'd2, 10'h3FF);
        shift_bits(32'hFFFFBEEF, 1'b1, -1);
        finish_write(10'h3FF, 4'b1100, 32'hBEEFBEEF, 3, 1'b0);

        // Misaligned and illegal stores never write.
        seen_wr = 1'b0;
        pulse_start(3'b010, 2'd1, 10'h001);
        shift_bits(32'h11111111, 1'b0, -1);
        finish_error("sw_off1");
        pulse_start(3'b001, 2'd3, 10'h002);
        shift_bits(32'h22222222, 1'b0, -1);
        finish_error("sh_off3");
        pulse_start(3'b011, 2'd0, 10'h003);
        shift_bits(32'h33333333, 1'b0, -1);
        finish_error("func_ill");
        check("mis_no_write", {63'd0, seen_wr}, 64'd0);
        check("mis_data_hold", {32'd0, bus.mem_data}, {32'd0, 32'hBEEFBEEF});

        // Reset after 17 bits of an SW abandons the store.
        pulse_start(3'b010, 2'd0, 10'h0F0);
        for (int i = 0; i < 17; i++) begin
            bit_valid = 1'b1;
            bit_in    = i[0];
            @(negedge clk);
        end
        bit_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_busy",  {63'd0, busy}, 64'd0);
        check("arst_data",  {32'd0, bus.mem_data}, 64'd0);
        check("arst_addr",  {54'd0, bus.mem_addr}, 64'd0);
        check("arst_mask",  {60'd0, bus.mem_mask}, 64'd0);
        check("arst_valid", {63'd0, bus.mem_wr_valid}, 64'd0);
        check("arst_mis",   {63'd0, misaligned}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start(3'b010, 2'd0, 10'h0F1);
        shift_bits(32'h00000001, 1'b0, -1);
        finish_write(10'h0F1, 4'hF, 32'h00000001, 0, 1'b0);

        @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
